// File: rtl/chan_sel_reg_if.sv
// Bus bundle for chan_sel_reg: the word bank and control go in, and the selected word comes out.
// valid semantics: valid=1 on an output cycle means dout/cur_ch were loaded on the
// previous edge from a legal channel. There is no ready signal and no backpressure.
interface chan_sel_reg_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] din;
    logic [SEL_W-1:0]          addr;
    logic                      mode;
    logic                      en;
    logic [WIDTH-1:0]          dout;
    logic [SEL_W-1:0]          cur_ch;
    logic                      valid;
    logic                      wrap;

    modport master (
        output din, addr, mode, en,
        input  dout, cur_ch, valid, wrap
    );

    modport slave (
        input  din, addr, mode, en,
        output dout, cur_ch, valid, wrap
    );
endinterface

// File: rtl/chan_sel_reg.sv
// Registered N-channel word selector with direct addressing and a round-robin scan mode.
// In scan mode each channel is held for DWELL enabled cycles.
module chan_sel_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic        clk,
    input  logic        reset,
    chan_sel_reg_if.slave bus,
    output logic [0:0]  dbg_state,
    output logic [7:0]  dbg_cnt
);

    localparam logic [0:0] ST_DIRECT = 1'b0;
    localparam logic [0:0] ST_SCAN   = 1'b1;

    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

    logic [0:0]       state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic [SEL_W-1:0] cur_q;
    logic             valid_q;
    logic             wrap_q;

    logic [WIDTH-1:0] ch_word [CHANNELS];
    logic             addr_legal;
    logic [SEL_W-1:0] start_ch;
    logic [SEL_W-1:0] next_ch;
    logic             at_last;
    logic             dwell_done;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_word[k] = bus.din[k*WIDTH +: WIDTH];
    end

    always_comb begin
        addr_legal = (bus.addr <= LAST_CH);
        start_ch   = addr_legal ? bus.addr : '0;
        at_last    = (cur_q == LAST_CH);
        next_ch    = at_last ? '0 : cur_q + 1'b1;
        dwell_done = (cnt_q == DWELL_LAST);
    end

    // A mode=0 edge is a direct-mode edge regardless of the current state, so the
    // scan->direct transition needs no separate branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DIRECT;
            cnt_q   <= '0;
            dout_q  <= '0;
            cur_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!bus.en) begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!bus.mode) begin
            state_q <= ST_DIRECT;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= addr_legal;
            if (addr_legal) begin
                dout_q <= ch_word[bus.addr];
                cur_q  <= bus.addr;
            end
        end else if (state_q == ST_DIRECT) begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b1;
            dout_q  <= ch_word[start_ch];
            cur_q   <= start_ch;
        end else begin
            valid_q <= 1'b1;
            if (dwell_done) begin
                cnt_q  <= '0;
                cur_q  <= next_ch;
                dout_q <= ch_word[next_ch];
                wrap_q <= at_last;
            end else begin
                cnt_q  <= cnt_q + 8'd1;
                dout_q <= ch_word[cur_q];
                wrap_q <= 1'b0;
            end
        end
    end

    assign bus.dout   = dout_q;
    assign bus.cur_ch = cur_q;
    assign bus.valid  = valid_q;
    assign bus.wrap   = wrap_q;
    assign dbg_state  = state_q;
    assign dbg_cnt    = cnt_q;

endmodule

// File: tb/tb_chan_sel_reg.sv
// Directed bench for chan_sel_reg: one 4-channel/DWELL=4 instance and one 3-channel/DWELL=1 instance.
module tb_chan_sel_reg;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [0:0] st_a, st_b;
  logic [7:0] cnt_a, cnt_b;

  chan_sel_reg_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus_a ();
  chan_sel_reg_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus_b ();

  chan_sel_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .dbg_state(st_a), .dbg_cnt(cnt_a)
  );

  chan_sel_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .dbg_state(st_b), .dbg_cnt(cnt_b)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] wa [4];
  int exp_ch;

  initial begin
    vectors     = 0;
    miscompares = 0;
    wa[0] = 8'h11; wa[1] = 8'h22; wa[2] = 8'h33; wa[3] = 8'h44;

    // reset with arbitrary inputs
    reset = 1'b1;
    bus_a.din  = $urandom;
    bus_a.addr = 2'd2;
    bus_a.mode = 1'b1;
    bus_a.en   = 1'b1;
    bus_b.din  = 24'($urandom);
    bus_b.addr = 2'd1;
    bus_b.mode = 1'b1;
    bus_b.en   = 1'b1;
    step();
    step();
    chk("rst_dout", 32'(bus_a.dout), 32'h0);
    chk("rst_cur", 32'(bus_a.cur_ch), 32'h0);
    chk("rst_valid", 32'(bus_a.valid), 32'h0);
    chk("rst_wrap", 32'(bus_a.wrap), 32'h0);
    chk("rst_b_dout", 32'(bus_b.dout), 32'h0);

    // direct select
    reset = 1'b0;
    bus_a.din  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus_a.mode = 1'b0;
    bus_b.en   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.addr = 2'(i);
      step();
      chk("dir_dout", 32'(bus_a.dout), 32'(wa[i]));
      chk("dir_cur", 32'(bus_a.cur_ch), 32'(i));
      chk("dir_valid", 32'(bus_a.valid), 32'h1);
    end

    // scan rotation from channel 2
    bus_a.mode = 1'b1;
    bus_a.addr = 2'd2;
    for (int i = 0; i < 17; i++) begin
      step();
      exp_ch = (2 + i / 4) % 4;
      chk("scan_cur", 32'(bus_a.cur_ch), 32'(exp_ch));
      chk("scan_wrap", 32'(bus_a.wrap), (i == 8) ? 32'h1 : 32'h0);
      chk("scan_dout", 32'(bus_a.dout), 32'(wa[exp_ch]));
      chk("scan_valid", 32'(bus_a.valid), 32'h1);
    end

    // freeze at counter=2 on channel 2
    step();
    step();
    chk("frz_cnt_pre", 32'(cnt_a), 32'h2);
    bus_a.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_cur", 32'(bus_a.cur_ch), 32'h2);
      chk("frz_dout", 32'(bus_a.dout), 32'h33);
      chk("frz_valid", 32'(bus_a.valid), 32'h0);
      chk("frz_wrap", 32'(bus_a.wrap), 32'h0);
      chk("frz_cnt", 32'(cnt_a), 32'h2);
    end
    bus_a.en = 1'b1;
    step();
    chk("resume1_cur", 32'(bus_a.cur_ch), 32'h2);
    chk("resume1_valid", 32'(bus_a.valid), 32'h1);
    step();
    chk("resume2_cur", 32'(bus_a.cur_ch), 32'h3);
    chk("resume2_dout", 32'(bus_a.dout), 32'h44);

    // walk to channel 1, one cycle into its dwell
    for (int i = 0; i < 9; i++) step();
    chk("live_pre_cur", 32'(bus_a.cur_ch), 32'h1);
    chk("live_pre_dout", 32'(bus_a.dout), 32'h22);
    bus_a.din = {8'h44, 8'h33, 8'h5A, 8'h11};
    step();
    chk("live_dout", 32'(bus_a.dout), 32'h5A);
    chk("live_cur", 32'(bus_a.cur_ch), 32'h1);

    // scan -> direct
    bus_a.mode = 1'b0;
    bus_a.addr = 2'd3;
    step();
    chk("s2d_dout", 32'(bus_a.dout), 32'h44);
    chk("s2d_cur", 32'(bus_a.cur_ch), 32'h3);
    chk("s2d_wrap", 32'(bus_a.wrap), 32'h0);
    chk("s2d_cnt", 32'(cnt_a), 32'h0);
    chk("s2d_state", 32'(st_a), 32'h0);

    // 3-channel instance: legal then illegal direct address
    bus_a.en   = 1'b0;
    bus_b.din  = {8'hC3, 8'hB2, 8'hA1};
    bus_b.en   = 1'b1;
    bus_b.mode = 1'b0;
    bus_b.addr = 2'd2;
    step();
    chk("b_dir_dout", 32'(bus_b.dout), 32'hC3);
    chk("b_dir_valid", 32'(bus_b.valid), 32'h1);
    bus_b.addr = 2'd3;
    step();
    chk("b_ill_valid", 32'(bus_b.valid), 32'h0);
    chk("b_ill_dout", 32'(bus_b.dout), 32'hC3);
    chk("b_ill_cur", 32'(bus_b.cur_ch), 32'h2);

    // scan from illegal start falls back to 0, DWELL=1 advances every edge
    bus_b.mode = 1'b1;
    step();
    chk("b_scan0_cur", 32'(bus_b.cur_ch), 32'h0);
    chk("b_scan0_dout", 32'(bus_b.dout), 32'hA1);
    chk("b_scan0_wrap", 32'(bus_b.wrap), 32'h0);
    step();
    chk("b_scan1_cur", 32'(bus_b.cur_ch), 32'h1);
    chk("b_scan1_dout", 32'(bus_b.dout), 32'hB2);
    step();
    chk("b_scan2_cur", 32'(bus_b.cur_ch), 32'h2);
    chk("b_scan2_wrap", 32'(bus_b.wrap), 32'h0);
    step();
    chk("b_scan3_cur", 32'(bus_b.cur_ch), 32'h0);
    chk("b_scan3_wrap", 32'(bus_b.wrap), 32'h1);
    step();
    chk("b_scan4_wrap", 32'(bus_b.wrap), 32'h0);
    chk("b_scan4_cur", 32'(bus_b.cur_ch), 32'h1);

    // scan -> direct with addr=1
    bus_b.mode = 1'b0;
    bus_b.addr = 2'd1;
    step();
    chk("b_s2d_dout", 32'(bus_b.dout), 32'hB2);
    chk("b_s2d_wrap", 32'(bus_b.wrap), 32'h0);
    chk("b_s2d_valid", 32'(bus_b.valid), 32'h1);

    // reset in mid-scan on both instances
    bus_a.en   = 1'b1;
    bus_a.mode = 1'b1;
    bus_a.addr = 2'd1;
    bus_b.mode = 1'b1;
    step();
    step();
    step();
    chk("mid_pre_valid", 32'(bus_a.valid), 32'h1);
    chk("mid_pre_state", 32'(st_a), 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_dout", 32'(bus_a.dout), 32'h0);
    chk("mid_rst_cur", 32'(bus_a.cur_ch), 32'h0);
    chk("mid_rst_valid", 32'(bus_a.valid), 32'h0);
    chk("mid_rst_state", 32'(st_a), 32'h0);
    chk("mid_rst_cnt", 32'(cnt_a), 32'h0);
    chk("mid_rst_b_cur", 32'(bus_b.cur_ch), 32'h0);
    chk("mid_rst_b_wrap", 32'(bus_b.wrap), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chan_sel_reg.md
# chan_sel_reg

Parametrised, registered N-channel word selector: the clocked successor to the 4:1 single-bit chooser. It selects one of `CHANNELS` input words either by explicit address (direct mode) or by an internal round-robin scanner with a programmable dwell time (scan mode). The selected word is registered with a qualifying `valid` flag. It sits between a bank of parallel data sources and a single downstream consumer (display/output port).

## Interface
- `WIDTH`, 8, bits per channel word
- `CHANNELS`, 4, number of input channels (2..16)
- `SEL_W`, 2, select width; must satisfy 2^SEL_W >= CHANNELS
- `DWELL`, 4, cycles spent on each channel in scan mode (1..255)

- `clk` in 1: single clock, all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `din` in CHANNELS*WIDTH: flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- `addr` in SEL_W: channel index used in direct mode and as the scan start channel
- `mode` in 1: 0 = direct, 1 = scan
- `en` in 1: operation enable; 0 freezes all internal state
- `dout` out WIDTH: registered selected word
- `cur_ch` out SEL_W: channel currently held in `dout`
- `valid` out 1: `dout` was updated on the last edge with a legal channel
- `wrap` out 1: one-cycle pulse when the scanner advances from channel CHANNELS-1 to channel 0

## Operation
- Reset: `dout`=0, `cur_ch`=0, `valid`=0, `wrap`=0, dwell counter=0, state=DIRECT.
- States: DIRECT and SCAN. `mode` is sampled every edge while `en`=1.
- DIRECT, en=1, addr<CHANNELS: `dout`<=din[addr], `cur_ch`<=addr, `valid`<=1.
- DIRECT, en=1, addr>=CHANNELS: `dout` and `cur_ch` hold, `valid`<=0 (illegal address, no update).
- DIRECT->SCAN (mode=1 while in DIRECT): scan starts at `addr` (or 0 if addr>=CHANNELS). Dwell counter<=0. That edge loads `dout`<=din[start], `cur_ch`<=start, `valid`<=1.
- SCAN, en=1: `dout`<=din[cur_ch] every edge, so live changes on the selected channel are tracked. `valid`<=1. Counter increments.
- SCAN, counter==DWELL-1: counter<=0 and `cur_ch` advances. At CHANNELS-1 it wraps to 0 and `wrap`<=1 for one cycle. On this same edge `dout` loads the new channel's word.
- SCAN->DIRECT (mode=0): behaves as a DIRECT-mode edge immediately. Counter<=0, `wrap`<=0.
- en=0, either state: `dout`, `cur_ch`, counter and state hold. `valid`<=0, `wrap`<=0. When `en` returns to 1, operation resumes with the counter value that was held.
- reset=1 overrides `en` and `mode` on the same edge. A reset in mid-scan returns the block to DIRECT at channel 0.
- DWELL=1: the channel advances every enabled edge.

## Timing
- Latency: 1 cycle from `din`/`addr` sampled to `dout` visible. No combinational path from inputs to outputs.
- Scan period: one full rotation = CHANNELS*DWELL enabled cycles.
- `wrap` is high for exactly one cycle per rotation, and is never asserted while en=0.
- Counter width is 8 bits. It never exceeds DWELL-1.

## Test plan
- Reset: hold reset 2 cycles with arbitrary inputs -> `dout`=0, `cur_ch`=0, `valid`=0, `wrap`=0. Check again by asserting reset mid-scan.
- Direct select: din={8'h44,8'h33,8'h22,8'h11}, mode=0, en=1, addr=0..3 on successive cycles -> `dout`=11,22,33,44, each one cycle after its address, `valid`=1.
- Scan rotation: DWELL=4, mode=1, addr=2 -> `cur_ch` sequence 2(x4), 3(x4), 0(x4), 1(x4)… and `wrap`=1 only on the cycle `cur_ch` becomes 0.
- Freeze: in scan mode, drop en for 3 cycles at counter=2 -> `dout` and `cur_ch` hold and `valid`=0. After en returns, the channel advances after exactly 2 more cycles.
- Live tracking: in scan mode, change din[cur_ch] mid-dwell from 8'h22 to 8'h5A -> `dout`=5A on the next edge, `cur_ch` unchanged.
- Illegal address and mode switch: CHANNELS=3, SEL_W=2, addr=3 in direct mode -> `valid`=0 and `dout` holds. Then switch scan->direct with addr=1 -> `dout`=din[1] next edge, `wrap`=0.
